// File: rtl/protocol_pkg.sv
// ============================================================================
//  Module      : protocol_pkg
//  Description : Shared definitions for the feedback status frame: transmit
//                FSM state encoding, default start-of-frame marker and the
//                number of payload words per frame.
//                `N_OSCILLATORS is normally supplied by constants.svh; a
//                default is provided here when it has not been defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

package protocol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HEADER   = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_CHECKSUM = 2'd3
    } state_t;

    localparam logic [7:0] C_SOF_DEFAULT = 8'hA5;
    localparam int         FRAME_WORDS   = 4;

endpackage

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
//  Module      : word_serializer
//  Description : Holds one WORD-bit value and presents it as WORD/WIDTH
//                chunks, most significant chunk first. A chunk is consumed
//                on chunk_valid && chunk_ready; chunk_last marks the final
//                chunk of the held word. A load overrides any consumption.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer #(
    parameter int WIDTH = 8,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WORD-1:0]  load_data,
    output logic [WIDTH-1:0] chunk,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic             chunk_last
);

    localparam int C_CHUNKS = WORD / WIDTH;
    localparam int C_CW     = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;

    logic [WORD-1:0] r_shift;
    logic [C_CW-1:0] r_idx;
    logic            r_valid;

    // Shift register advances one chunk per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_shift <= load_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && chunk_ready) begin
            r_shift <= r_shift << WIDTH;
            if (chunk_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + C_CW'(1);
            end
        end
    end

    assign chunk       = r_shift[WORD-1 -: WIDTH];
    assign chunk_valid = r_valid;
    assign chunk_last  = (r_idx == C_CW'(C_CHUNKS - 1));

endmodule

`default_nettype wire

// File: rtl/feedback_transmit_unit.sv
// ============================================================================
//  Module      : feedback_transmit_unit
//  Description : Sends a status frame to an SPI slave transmitter: SOF,
//                volume, reverb, oscillator-active flags and a running frame
//                counter, each payload word split MSB chunk first. Inputs are
//                snapshotted when the frame starts. Optional feature macro
//                FEEDBACK_CHECKSUM_EN appends an XOR checksum of SOF and all
//                payload chunks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

module feedback_transmit_unit
    import protocol_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               WORD  = 32,
    parameter logic [WIDTH-1:0] SOF   = WIDTH'(C_SOF_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD-1:0]           volume,
    input  logic [WORD-1:0]           reverb,
    input  logic [`N_OSCILLATORS-1:0] osc_active,
    output logic [WIDTH-1:0]          tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] C_LAST_WORD = 2'(FRAME_WORDS - 1);

    state_t                    r_state;
    logic [WORD-1:0]           r_vol;
    logic [WORD-1:0]           r_rev;
    logic [`N_OSCILLATORS-1:0] r_osc;
    logic [WORD-1:0]           r_fc_snap;
    logic [WORD-1:0]           r_frame_count;
    logic [1:0]                r_word;
    logic                      r_out_final;
    logic [WIDTH-1:0]          r_tx_data;
    logic                      r_tx_valid;
    logic                      r_done;
`ifdef FEEDBACK_CHECKSUM_EN
    logic [WIDTH-1:0]          r_csum;
`endif

    logic                      w_hs;
    logic                      w_emit;
    logic                      w_ser_load;
    logic [WORD-1:0]           w_ser_data;
    logic                      w_ser_ready;
    logic [WIDTH-1:0]          w_ser_chunk;
    logic                      w_ser_valid;
    logic                      w_ser_last;
    logic [WORD-1:0]           w_next_word;

    assign w_hs = r_tx_valid && tx_ready;

    // A payload chunk moves onto tx_data whenever the word currently shown is
    // accepted and it is not the last payload chunk of the frame
    assign w_emit = w_hs && w_ser_valid &&
                    ((r_state == ST_HEADER) ||
                     ((r_state == ST_PAYLOAD) && !r_out_final));

    // Payload word that follows the one currently held by the serializer
    always_comb begin
        w_next_word = r_fc_snap;
        case (r_word)
            2'd0:    w_next_word = r_rev;
            2'd1:    w_next_word = WORD'(r_osc);
            default: w_next_word = r_fc_snap;
        endcase
    end

    // Serializer control: load P0 on header entry, then advance or reload
    always_comb begin
        w_ser_load  = 1'b0;
        w_ser_data  = r_vol;
        w_ser_ready = 1'b0;
        if ((r_state == ST_HEADER) && !r_tx_valid) begin
            w_ser_load = 1'b1;
        end else if (w_emit) begin
            if (w_ser_last) begin
                w_ser_load = (r_word != C_LAST_WORD);
                w_ser_data = w_next_word;
            end else begin
                w_ser_ready = 1'b1;
            end
        end
    end

    word_serializer #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load        (w_ser_load),
        .load_data   (w_ser_data),
        .chunk       (w_ser_chunk),
        .chunk_valid (w_ser_valid),
        .chunk_ready (w_ser_ready),
        .chunk_last  (w_ser_last)
    );

    // Frame sequencer with registered tx outputs and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_vol         <= '0;
            r_rev         <= '0;
            r_osc         <= '0;
            r_fc_snap     <= '0;
            r_frame_count <= '0;
            r_word        <= '0;
            r_out_final   <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_done        <= 1'b0;
`ifdef FEEDBACK_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_emit) begin
                r_tx_data   <= w_ser_chunk;
                r_out_final <= w_ser_last && (r_word == C_LAST_WORD);
                if (w_ser_last && (r_word != C_LAST_WORD)) begin
                    r_word <= r_word + 2'd1;
                end
`ifdef FEEDBACK_CHECKSUM_EN
                r_csum <= r_csum ^ w_ser_chunk;
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vol       <= volume;
                        r_rev       <= reverb;
                        r_osc       <= osc_active;
                        r_fc_snap   <= r_frame_count;
                        r_word      <= '0;
                        r_out_final <= 1'b0;
                        r_state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= SOF;
`ifdef FEEDBACK_CHECKSUM_EN
                        r_csum     <= SOF;
`endif
                    end else if (w_hs) begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_hs && r_out_final) begin
`ifdef FEEDBACK_CHECKSUM_EN
                        r_tx_data <= r_csum;
                        r_state   <= ST_CHECKSUM;
`else
                        r_tx_valid    <= 1'b0;
                        r_tx_data     <= '0;
                        r_done        <= 1'b1;
                        r_frame_count <= r_frame_count + WORD'(1);
                        r_state       <= ST_IDLE;
`endif
                    end
                end
                default: begin
`ifdef FEEDBACK_CHECKSUM_EN
                    if (w_hs) begin
                        r_tx_valid    <= 1'b0;
                        r_tx_data     <= '0;
                        r_done        <= 1'b1;
                        r_frame_count <= r_frame_count + WORD'(1);
                        r_state       <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_feedback_transmit_unit.sv
// ============================================================================
//  Module      : tb_feedback_transmit_unit
//  Description : Directed self-checking bench for feedback_transmit_unit.
//                A second, narrow instance (WORD = WIDTH = 8) makes the
//                frame counter wrap reachable in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

module tb_feedback_transmit_unit;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      tx_ready;
    logic [31:0]               volume;
    logic [31:0]               reverb;
    logic [`N_OSCILLATORS-1:0] osc_active;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      busy;
    logic                      done;

    logic                      n_start;
    logic [7:0]                n_volume;
    logic [7:0]                n_reverb;
    logic [`N_OSCILLATORS-1:0] n_osc;
    logic [7:0]                n_tx_data;
    logic                      n_tx_valid;
    logic                      n_busy;
    logic                      n_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    feedback_transmit_unit #(
        .WIDTH (8),
        .WORD  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .volume     (volume),
        .reverb     (reverb),
        .osc_active (osc_active),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    feedback_transmit_unit #(
        .WIDTH (8),
        .WORD  (8)
    ) dut_narrow (
        .clk        (clk),
        .rst        (rst),
        .start      (n_start),
        .volume     (n_volume),
        .reverb     (n_reverb),
        .osc_active (n_osc),
        .tx_data    (n_tx_data),
        .tx_valid   (n_tx_valid),
        .tx_ready   (tx_ready),
        .busy       (n_busy),
        .done       (n_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected frame: SOF, four words MSB byte first, optional XOR checksum
    task automatic build_frame(input logic [31:0] v, input logic [31:0] r,
                               input logic [31:0] o, input logic [31:0] f);
        logic [31:0] words [4];
        logic [31:0] w;
        logic [7:0]  x;
        words[0] = v; words[1] = r; words[2] = o; words[3] = f;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 4; k++) begin
            w = words[k];
            for (int c = 3; c >= 0; c--) exp_q.push_back(w[c*8 +: 8]);
        end
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef FEEDBACK_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Pulse start at a falling edge; SOF is due two falling edges later
    task automatic kick_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s.latency_valid", tag), {31'd0, tx_valid}, 32'd0);
        check($sformatf("%s.latency_busy", tag), {31'd0, busy}, 32'd1);
        @(negedge clk);
    endtask

    task automatic recv_frame(input string tag, input int stall_idx, input int stall_len,
                              input int poke_idx, input int abort_idx);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s.valid[%0d]", tag, i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("%s.data[%0d]", tag, i), {24'd0, tx_data}, {24'd0, exp_q[i]});
            if (i == abort_idx) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check($sformatf("%s.abort_valid", tag), {31'd0, tx_valid}, 32'd0);
                check($sformatf("%s.abort_busy", tag), {31'd0, busy}, 32'd0);
                check($sformatf("%s.abort_done", tag), {31'd0, done}, 32'd0);
                @(negedge clk);
                check($sformatf("%s.abort_nodone", tag), {31'd0, done}, 32'd0);
                return;
            end
            if (i == stall_idx) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check($sformatf("%s.stall_valid[%0d]", tag, s), {31'd0, tx_valid}, 32'd1);
                    check($sformatf("%s.stall_data[%0d]", tag, s), {24'd0, tx_data}, {24'd0, exp_q[i]});
                end
                tx_ready = 1'b1;
            end
            if (i == poke_idx) begin
                volume = 32'hFFFF_FFFF;
                start  = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check($sformatf("%s.done", tag), {31'd0, done}, 32'd1);
        check($sformatf("%s.done_busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s.done_valid", tag), {31'd0, tx_valid}, 32'd0);
    endtask

    // One frame on the narrow instance; returns its P3 byte and word count
    task automatic narrow_frame(output logic [7:0] p3, output int nwords, output bit ok);
        p3     = 8'h00;
        nwords = 0;
        ok     = 1'b0;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (n_done) begin
                ok = 1'b1;
                break;
            end
            if (n_tx_valid) begin
                if (nwords == 4) p3 = n_tx_data;
                nwords++;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p3;
        int         nw;
        bit         ok;
        int         timeouts;

        rst        = 1'b1;
        start      = 1'b0;
        tx_ready   = 1'b1;
        volume     = '0;
        reverb     = '0;
        osc_active = '0;
        n_start    = 1'b0;
        n_volume   = 8'h3C;
        n_reverb   = 8'hC3;
        n_osc      = '0;
        repeat (3) @(negedge clk);
        check("reset.tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset.tx_data", {24'd0, tx_data}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.narrow_valid", {31'd0, n_tx_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-throughput frame with hand-written byte sequence
        volume     = 32'h1122_3344;
        reverb     = 32'h5566_7788;
        osc_active = `N_OSCILLATORS'(1);
        exp_q = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef FEEDBACK_CHECKSUM_EN
        exp_q.push_back(8'h2C);
`endif
        kick_start("A");
        recv_frame("A", -1, 0, -1, -1);
        @(negedge clk);
        check("A.done_pulse_end", {31'd0, done}, 32'd0);

        // Back-pressure on chunk 2 of P0 (0x22) for three cycles
        build_frame(32'h1122_3344, 32'h5566_7788, 32'h1, 32'h1);
        kick_start("B");
        recv_frame("B", 2, 3, -1, -1);
        @(negedge clk);

        // Reset while P1 is on the wire
        build_frame(32'h1122_3344, 32'h5566_7788, 32'h1, 32'h2);
        kick_start("C");
        recv_frame("C", -1, 0, -1, 6);

        // Counter restarts at 0; volume change and start mid-frame are ignored
        build_frame(32'h1122_3344, 32'h5566_7788, 32'h1, 32'h0);
        kick_start("D");
        recv_frame("D", -1, 0, 4, -1);
        @(negedge clk);
        check("D.not_queued_valid", {31'd0, tx_valid}, 32'd0);
        check("D.not_queued_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("D.not_queued_valid2", {31'd0, tx_valid}, 32'd0);

        // Next frame carries the new volume and P3 = 1
        build_frame(32'hFFFF_FFFF, 32'h5566_7788, 32'h1, 32'h1);
        kick_start("E");
        recv_frame("E", -1, 0, -1, -1);

        // Start in the done cycle launches the following frame
        build_frame(32'hFFFF_FFFF, 32'h5566_7788, 32'h1, 32'h2);
        kick_start("F");
        recv_frame("F", -1, 0, -1, -1);
        @(negedge clk);
        check("F.done_pulse_end", {31'd0, done}, 32'd0);

        // Narrow instance: run the 8-bit frame counter up to all-ones
        timeouts = 0;
        for (int f = 0; f < 255; f++) begin
            narrow_frame(p3, nw, ok);
            if (!ok) timeouts++;
            @(negedge clk);
        end
        check("wrap.timeouts", timeouts, 32'd0);
        narrow_frame(p3, nw, ok);
        check("wrap.ff_done", {31'd0, ok}, 32'd1);
        check("wrap.p3_ff", {24'd0, p3}, 32'h0000_00FF);
`ifdef FEEDBACK_CHECKSUM_EN
        check("wrap.len_ff", nw, 32'd6);
`else
        check("wrap.len_ff", nw, 32'd5);
`endif
        @(negedge clk);
        narrow_frame(p3, nw, ok);
        check("wrap.00_done", {31'd0, ok}, 32'd1);
        check("wrap.p3_00", {24'd0, p3}, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
